// File: rtl/lcd_write_scheduler_if.sv
// ---------------------------------------------------------------------------
// lcd_write_scheduler_if
//   Bundles the requester handshake and the LCD1602 parallel bus of the
//   lcd_write_scheduler into one interface.
//
//   Requester side (driven by master, read by slave):
//     req       [NUM_REQ]    level request per requester
//     req_row   [NUM_REQ]    target row per requester (0 = line 1, 1 = line 2)
//     req_col   [4*NUM_REQ]  target column, requester i at [4i+3:4i]
//     req_char  [8*NUM_REQ]  ASCII byte, requester i at [8i+7:8i]
//   Scheduler side (driven by slave, read by master):
//     grant     [NUM_REQ]    one-cycle one-hot accept pulse
//     init_done              power-up/config sequence finished
//     busy                   scheduler is not idle
//     rs, rw, enable, data   LCD1602 bus (rw is always 0)
// ---------------------------------------------------------------------------
interface lcd_write_scheduler_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   req_row;
  logic [4*NUM_REQ-1:0] req_col;
  logic [8*NUM_REQ-1:0] req_char;
  logic [NUM_REQ-1:0]   grant;
  logic                 init_done;
  logic                 busy;
  logic                 rs;
  logic                 rw;
  logic                 enable;
  logic [7:0]           data;

  // Requester / display-client side.
  modport master (
    output req, req_row, req_col, req_char,
    input  grant, init_done, busy, rs, rw, enable, data
  );

  // Scheduler side.
  modport slave (
    input  req, req_row, req_col, req_char,
    output grant, init_done, busy, rs, rw, enable, data
  );
endinterface

// File: rtl/lcd_write_scheduler.sv
// ---------------------------------------------------------------------------
// lcd_write_scheduler
//   Shares one LCD1602 8-bit parallel bus between NUM_REQ requesters.
//   After reset it waits PWRUP_CYCLES, then sends the configuration commands
//   0x38, 0x06, 0x0C, 0x01. Afterwards it grants single-character writes in
//   round-robin order. A cursor-set command is only sent when the target
//   DDRAM address differs from the LCD's own auto-incremented position.
//
//   Every byte on the bus takes SETUP (1 cycle), STROBE (EN_CYCLES, enable
//   high) and WAIT (CLR_WAIT_CYCLES for the clear command, otherwise
//   CMD_WAIT_CYCLES). rs/data are held stable for the whole byte.
//
//   Ports:
//     clk    system clock
//     reset  asynchronous, active-high reset
//     bus    lcd_write_scheduler_if.slave (requests in, grant/status/LCD out)
// ---------------------------------------------------------------------------
module lcd_write_scheduler #(
  parameter int NUM_REQ         = 3,
  parameter int EN_CYCLES       = 25,
  parameter int CMD_WAIT_CYCLES = 2500,
  parameter int CLR_WAIT_CYCLES = 100000,
  parameter int PWRUP_CYCLES    = 2000000
) (
  input  logic                 clk,
  input  logic                 reset,
  lcd_write_scheduler_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // One shared phase counter, wide enough for the longest phase.
  localparam int MAX_AB  = (EN_CYCLES > CMD_WAIT_CYCLES) ? EN_CYCLES : CMD_WAIT_CYCLES;
  localparam int MAX_CD  = (CLR_WAIT_CYCLES > PWRUP_CYCLES) ? CLR_WAIT_CYCLES : PWRUP_CYCLES;
  localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Counters run down from N-1 to 0, so a phase lasts exactly N cycles.
  localparam logic [CNT_W-1:0] PWRUP_LOAD = CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] EN_LOAD    = CNT_W'(EN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CMD_LOAD   = CNT_W'(CMD_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLR_LOAD   = CNT_W'(CLR_WAIT_CYCLES - 1);

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [1:0] INIT_LAST = 2'd3;

  typedef enum logic [2:0] {
    S_PWRUP,
    S_INIT,
    S_IDLE,
    S_ARB,
    S_SET_ADDR,
    S_SEND_CHAR
  } state_t;

  typedef enum logic [1:0] {
    PH_SETUP,
    PH_STROBE,
    PH_WAIT
  } phase_t;

  // Configuration commands in issue order: 8-bit/2-line, entry increment,
  // display on/cursor off, clear.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h06;
      2'd2:    return 8'h0C;
      default: return CMD_CLEAR;
    endcase
  endfunction

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  state_t             r_state;
  phase_t             r_phase;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_init_idx;
  logic               r_init_done;
  logic               r_rs;
  logic [7:0]         r_data;
  logic               r_enable;
  logic [PTR_W-1:0]   r_ptr;
  logic [3:0]         r_col;
  logic [7:0]         r_char;
  logic [7:0]         r_addr;
  logic [7:0]         r_cur_addr;
  logic               r_cur_valid;

  state_t             w_state_nxt;
  phase_t             w_phase_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [1:0]         w_init_idx_nxt;
  logic               w_init_done_nxt;
  logic               w_rs_nxt;
  logic [7:0]         w_data_nxt;
  logic               w_enable_nxt;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic [3:0]         w_col_nxt;
  logic [7:0]         w_char_nxt;
  logic [7:0]         w_addr_nxt;
  logic [7:0]         w_cur_addr_nxt;
  logic               w_cur_valid_nxt;
  logic               w_byte_done;
  logic [NUM_REQ-1:0] w_grant;

  // -------------------------------------------------------------------------
  // Round-robin selection: first set req bit above the pointer, wrapping.
  // -------------------------------------------------------------------------
  logic               w_found;
  logic [PTR_W-1:0]   w_sel;
  logic               w_sel_row;
  logic [3:0]         w_sel_col;
  logic [7:0]         w_sel_char;
  logic [7:0]         w_arb_addr;

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_found && bus.req[(int'(r_ptr) + k) % NUM_REQ]) begin
        w_found = 1'b1;
        w_sel   = PTR_W'((int'(r_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign w_sel_row  = bus.req_row[w_sel];
  assign w_sel_col  = bus.req_col[4*int'(w_sel) +: 4];
  assign w_sel_char = bus.req_char[8*int'(w_sel) +: 8];
  // DDRAM address command: 0x80 | row*0x40 | col.
  assign w_arb_addr = {1'b1, w_sel_row, 2'b00, w_sel_col};

  // The LCD's busy time after clear is far longer than for any other byte.
  logic w_is_clear;
  assign w_is_clear = !r_rs && (r_data == CMD_CLEAR);

  logic w_on_bus;
  assign w_on_bus = (r_state == S_INIT) || (r_state == S_SET_ADDR) ||
                    (r_state == S_SEND_CHAR);

  // -------------------------------------------------------------------------
  // Next-state / next-output logic. Outputs are registered, so whatever is
  // chosen here is what the bus shows while the FSM sits in the next state.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt     = r_state;
    w_phase_nxt     = r_phase;
    w_cnt_nxt       = r_cnt;
    w_init_idx_nxt  = r_init_idx;
    w_init_done_nxt = r_init_done;
    w_rs_nxt        = r_rs;
    w_data_nxt      = r_data;
    w_enable_nxt    = r_enable;
    w_ptr_nxt       = r_ptr;
    w_col_nxt       = r_col;
    w_char_nxt      = r_char;
    w_addr_nxt      = r_addr;
    w_cur_addr_nxt  = r_cur_addr;
    w_cur_valid_nxt = r_cur_valid;
    w_byte_done     = 1'b0;
    w_grant         = '0;

    // Shared byte sub-sequence for all bus-writing states.
    if (w_on_bus) begin
      case (r_phase)
        PH_SETUP: begin
          w_phase_nxt  = PH_STROBE;
          w_enable_nxt = 1'b1;
          w_cnt_nxt    = EN_LOAD;
        end
        PH_STROBE: begin
          if (r_cnt == '0) begin
            w_phase_nxt  = PH_WAIT;
            w_enable_nxt = 1'b0;
            w_cnt_nxt    = w_is_clear ? CLR_LOAD : CMD_LOAD;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
        default: begin
          if (r_cnt == '0) begin
            w_byte_done = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
      endcase
    end

    case (r_state)
      S_PWRUP: begin
        if (r_cnt == '0) begin
          w_state_nxt    = S_INIT;
          w_phase_nxt    = PH_SETUP;
          w_init_idx_nxt = 2'd0;
          w_rs_nxt       = 1'b0;
          w_data_nxt     = init_cmd(2'd0);
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end

      S_INIT: begin
        if (w_byte_done) begin
          if (r_init_idx == INIT_LAST) begin
            w_state_nxt     = S_IDLE;
            w_init_done_nxt = 1'b1;
            // Clear homes the cursor, but a write to 0x80 must still be
            // issued explicitly, so start with no known position.
            w_cur_valid_nxt = 1'b0;
          end else begin
            w_init_idx_nxt = r_init_idx + 2'd1;
            w_phase_nxt    = PH_SETUP;
            w_rs_nxt       = 1'b0;
            w_data_nxt     = init_cmd(r_init_idx + 2'd1);
          end
        end
      end

      S_IDLE: begin
        if (|bus.req) begin
          w_state_nxt = S_ARB;
        end
      end

      S_ARB: begin
        if (w_found) begin
          w_grant     = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel;
          w_ptr_nxt   = w_sel;
          w_col_nxt   = w_sel_col;
          w_char_nxt  = w_sel_char;
          w_addr_nxt  = w_arb_addr;
          w_phase_nxt = PH_SETUP;
          if (!r_cur_valid || (w_arb_addr != r_cur_addr)) begin
            w_state_nxt = S_SET_ADDR;
            w_rs_nxt    = 1'b0;
            w_data_nxt  = w_arb_addr;
          end else begin
            w_state_nxt = S_SEND_CHAR;
            w_rs_nxt    = 1'b1;
            w_data_nxt  = w_sel_char;
          end
        end else begin
          // Request vanished before it could be served.
          w_state_nxt = S_IDLE;
        end
      end

      S_SET_ADDR: begin
        if (w_byte_done) begin
          w_state_nxt = S_SEND_CHAR;
          w_phase_nxt = PH_SETUP;
          w_rs_nxt    = 1'b1;
          w_data_nxt  = r_char;
        end
      end

      S_SEND_CHAR: begin
        if (w_byte_done) begin
          w_state_nxt = S_IDLE;
          // After column 15 the LCD increments into off-screen DDRAM, so the
          // next visible cell always needs an explicit address.
          if (r_col == 4'd15) begin
            w_cur_valid_nxt = 1'b0;
          end else begin
            w_cur_addr_nxt  = r_addr + 8'd1;
            w_cur_valid_nxt = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = S_PWRUP;
        w_cnt_nxt   = PWRUP_LOAD;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      r_state     <= S_PWRUP;
      r_phase     <= PH_SETUP;
      r_cnt       <= PWRUP_LOAD;
      r_init_idx  <= 2'd0;
      r_init_done <= 1'b0;
      r_rs        <= 1'b0;
      r_data      <= 8'h00;
      r_enable    <= 1'b0;
      r_ptr       <= PTR_W'(NUM_REQ - 1);
      r_col       <= 4'd0;
      r_char      <= 8'h00;
      r_addr      <= 8'h00;
      r_cur_addr  <= 8'h00;
      r_cur_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_cnt       <= w_cnt_nxt;
      r_init_idx  <= w_init_idx_nxt;
      r_init_done <= w_init_done_nxt;
      r_rs        <= w_rs_nxt;
      r_data      <= w_data_nxt;
      r_enable    <= w_enable_nxt;
      r_ptr       <= w_ptr_nxt;
      r_col       <= w_col_nxt;
      r_char      <= w_char_nxt;
      r_addr      <= w_addr_nxt;
      r_cur_addr  <= w_cur_addr_nxt;
      r_cur_valid <= w_cur_valid_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // grant is decoded from the ARB state, so reset removes it immediately.
  assign bus.grant     = w_grant;
  assign bus.init_done = r_init_done;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.rs        = r_rs;
  assign bus.rw        = 1'b0;
  assign bus.enable    = r_enable;
  assign bus.data      = r_data;

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// ---------------------------------------------------------------------------
// tb_lcd_write_scheduler
//   Directed bench for lcd_write_scheduler with short timing parameters.
//   Outputs are sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_lcd_write_scheduler;

  localparam int NUM_REQ = 3;
  localparam int EN_C    = 2;
  localparam int CMD_C   = 4;
  localparam int CLR_C   = 8;
  localparam int PWR_C   = 10;

  logic clk;
  logic reset;

  lcd_write_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

  lcd_write_scheduler #(
    .NUM_REQ         (NUM_REQ),
    .EN_CYCLES       (EN_C),
    .CMD_WAIT_CYCLES (CMD_C),
    .CLR_WAIT_CYCLES (CLR_C),
    .PWRUP_CYCLES    (PWR_C)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int early_grants = 0;

  // A grant while init_done is low is never allowed.
  always @(negedge clk) begin
    if (!reset && bus.grant != '0 && !bus.init_done) early_grants++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Follows one byte on the bus: steps until enable rises (exp_lead steps),
  // then checks rs/data, pulse width and stability through the WAIT window.
  // Returns positioned on the last WAIT sample.
  task automatic expect_byte(input string tag, input logic exp_rs,
                             input logic [7:0] exp_data, input int exp_wait,
                             input int exp_lead);
    int n = 0;
    int w = 0;
    logic hold_ok = 1'b1;
    while (bus.enable !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check({tag, "_lead"}, n, exp_lead);
    check({tag, "_rs"}, bus.rs, exp_rs);
    check({tag, "_data"}, bus.data, exp_data);
    while (bus.enable === 1'b1 && w < 200) begin
      if (bus.rs !== exp_rs || bus.data !== exp_data) hold_ok = 1'b0;
      step();
      w++;
    end
    check({tag, "_width"}, w, EN_C);
    if (bus.rs !== exp_rs || bus.data !== exp_data) hold_ok = 1'b0;
    for (int i = 1; i < exp_wait; i++) begin
      step();
      if (bus.enable !== 1'b0 || bus.rs !== exp_rs || bus.data !== exp_data) hold_ok = 1'b0;
    end
    check({tag, "_hold"}, hold_ok, 1'b1);
  endtask

  // Power-up wait and configuration, starting right after reset release.
  task automatic run_init(input string tag);
    expect_byte({tag, "_i38"}, 1'b0, 8'h38, CMD_C, PWR_C + 1);
    check({tag, "_done_lo"}, bus.init_done, 1'b0);
    expect_byte({tag, "_i06"}, 1'b0, 8'h06, CMD_C, 2);
    expect_byte({tag, "_i0c"}, 1'b0, 8'h0C, CMD_C, 2);
    expect_byte({tag, "_i01"}, 1'b0, 8'h01, CLR_C, 2);
    step();
    check({tag, "_init_done"}, bus.init_done, 1'b1);
    check({tag, "_busy_lo"}, bus.busy, 1'b0);
  endtask

  task automatic wait_grant(input string tag, input int idx);
    int n = 0;
    while (bus.grant == '0 && n < 100) begin
      step();
      n++;
    end
    check({tag, "_grant"}, bus.grant, 32'(1) << idx);
  endtask

  // One requester writes one character; exp_cmd says whether a cursor-set
  // command (exp_addr) must precede the data byte.
  task automatic do_write(input string tag, input int idx, input logic row,
                          input logic [3:0] col, input logic [7:0] ch,
                          input logic exp_cmd, input logic [7:0] exp_addr);
    int g;
    bus.req_row[idx]        = row;
    bus.req_col[4*idx +: 4] = col;
    bus.req_char[8*idx +: 8] = ch;
    bus.req[idx]            = 1'b1;
    wait_grant(tag, idx);
    g = cyc;
    step();
    bus.req[idx] = 1'b0;
    check({tag, "_pulse"}, bus.grant, 0);
    // Fields change after grant; the transaction must keep the latched ones.
    bus.req_row[idx]         = ~row;
    bus.req_col[4*idx +: 4]  = ~col;
    bus.req_char[8*idx +: 8] = ~ch;
    if (exp_cmd) begin
      expect_byte({tag, "_cmd"}, 1'b0, exp_addr, CMD_C, 1);
      expect_byte({tag, "_chr"}, 1'b1, ch, CMD_C, 2);
    end else begin
      expect_byte({tag, "_chr"}, 1'b1, ch, CMD_C, 1);
    end
    step();
    check({tag, "_busy_lo"}, bus.busy, 1'b0);
    check({tag, "_busy_len"}, cyc - g - 1, (exp_cmd ? 2 : 1) * (1 + EN_C + CMD_C));
  endtask

  initial begin
    int exp_seq [9] = '{0, 1, 2, 0, 1, 2, 0, 2, 0};
    int n;

    reset        = 1'b1;
    bus.req      = '0;
    bus.req_row  = '0;
    bus.req_col  = '0;
    bus.req_char = '0;

    // 1. Reset values, then power-up and init.
    repeat (3) step();
    check("rst_rs", bus.rs, 1'b0);
    check("rst_rw", bus.rw, 1'b0);
    check("rst_en", bus.enable, 1'b0);
    check("rst_data", bus.data, 8'h00);
    check("rst_grant", bus.grant, 0);
    check("rst_init_done", bus.init_done, 1'b0);
    check("rst_busy", bus.busy, 1'b1);
    reset = 1'b0;
    run_init("t1");

    // 2. Single write with address command.
    do_write("t2", 0, 1'b1, 4'd3, "A", 1'b1, 8'hC3);

    // 3. Sequential columns skip the address command; a jump does not.
    do_write("t3a", 0, 1'b0, 4'd5, "B", 1'b1, 8'h85);
    do_write("t3b", 0, 1'b0, 4'd6, "C", 1'b0, 8'h00);
    do_write("t3c", 0, 1'b0, 4'd9, "D", 1'b1, 8'h89);

    // 5. Column 15 invalidates the cursor.
    do_write("t5a", 0, 1'b0, 4'd15, "E", 1'b1, 8'h8F);
    do_write("t5b", 0, 1'b1, 4'd0,  "F", 1'b1, 8'hC0);
    do_write("t5c", 1, 1'b0, 4'd15, "G", 1'b1, 8'h8F);
    do_write("t5d", 2, 1'b0, 4'd0,  "H", 1'b1, 8'h80);

    // 4. Round robin with all requests held (last grant was requester 2).
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_row[i]         = 1'b1;
      bus.req_col[4*i +: 4]  = 4'(i);
      bus.req_char[8*i +: 8] = 8'h30 + 8'(i);
    end
    bus.req = '1;
    for (int i = 0; i < 9; i++) begin
      wait_grant($sformatf("t4_%0d", i), exp_seq[i]);
      step();
      check($sformatf("t4_pulse%0d", i), bus.grant, 0);
      if (i == 4) bus.req[1] = 1'b0;
    end
    bus.req = '0;
    n = 0;
    while (bus.busy && n < 100) begin
      step();
      n++;
    end
    check("t4_idle", bus.busy, 1'b0);

    // 6. Reset in the middle of a data strobe.
    bus.req_row[0]      = 1'b0;
    bus.req_col[3:0]    = 4'd1;
    bus.req_char[7:0]   = "R";
    bus.req[0]          = 1'b1;
    wait_grant("t6", 0);
    step();
    bus.req[0] = 1'b0;
    n = 0;
    while (!(bus.enable === 1'b1 && bus.rs === 1'b1) && n < 100) begin
      step();
      n++;
    end
    check("t6_in_strobe", bus.enable, 1'b1);
    #2;
    reset   = 1'b1;
    bus.req = '1;
    #1;
    check("t6_async_en", bus.enable, 1'b0);
    check("t6_async_done", bus.init_done, 1'b0);
    check("t6_async_grant", bus.grant, 0);
    step();
    step();
    reset = 1'b0;
    run_init("t6");
    wait_grant("t6_post", 0);
    check("t6_no_early_grant", early_grants, 0);
    step();
    bus.req = '0;
    n = 0;
    while (bus.busy && n < 100) begin
      step();
      n++;
    end
    check("t6_idle", bus.busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
